// File: rtl/core_state_seq.sv
// Power-on / restart sequencer for a multi-core cluster.
// Holds per-core resets, waits for config handshakes, then releases.
module core_state_seq #(
  parameter int NUM_CORES      = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 restart,
  input  logic [NUM_CORES-1:0] core_enable,
  input  logic [NUM_CORES-1:0] config_done,
  output logic [NUM_CORES-1:0] core_rst_n,
  output logic [2:0]           state,
  output logic                 cluster_on,
  output logic                 fault,
  output logic [NUM_CORES-1:0] done_seen
);

  typedef enum logic [2:0] {
    S_OFF    = 3'b000,
    S_HOLD   = 3'b001,
    S_CONFIG = 3'b010,
    S_ON     = 3'b011,
    S_FAULT  = 3'b100
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_t               state_q;
  state_t               state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [CNT_W-1:0]     cnt_inc;
  logic [NUM_CORES-1:0] mask_q;
  logic [NUM_CORES-1:0] mask_d;
  logic [NUM_CORES-1:0] seen_q;
  logic [NUM_CORES-1:0] seen_d;
  logic [NUM_CORES-1:0] hit;
  logic [NUM_CORES-1:0] rst_q;
  logic [NUM_CORES-1:0] rst_d;
  logic                 on_q;
  logic                 on_d;
  logic                 fault_q;
  logic                 fault_d;
  logic                 legal;

  // State, counter, mask and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      mask_q  <= '0;
      seen_q  <= '0;
      rst_q   <= '0;
      on_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      seen_q  <= seen_d;
      rst_q   <= rst_d;
      on_q    <= on_d;
      fault_q <= fault_d;
    end
  end

  // Next state, counter and outputs; controls override the
  // per-state sequencing, restart before start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    seen_d  = seen_q;
    rst_d   = '0;
    on_d    = 1'b0;
    fault_d = 1'b0;
    legal   = (state_q <= S_FAULT);
    hit     = seen_q | (config_done & mask_q);
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    unique case (state_q)
      S_OFF: begin
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = S_CONFIG;
        else cnt_d = cnt_inc;
      end
      S_CONFIG: begin
        seen_d = hit;
        if (hit == mask_q) state_d = S_ON;
        else if (TO_EN && cnt_q == TO_LAST) state_d = S_FAULT;
        else cnt_d = cnt_inc;
      end
      S_ON: begin
      end
      S_FAULT: begin
      end
      default: begin
        state_d = S_OFF;
      end
    endcase

    if (legal) begin
      if (restart) begin
        state_d = S_HOLD;
        mask_d  = core_enable;
        seen_d  = '0;
        cnt_d   = '0;
      end else if (start) begin
        if (state_q == S_OFF) begin
          if (|core_enable) begin
            state_d = S_HOLD;
            mask_d  = core_enable;
            seen_d  = '0;
            cnt_d   = '0;
          end
        end else begin
          state_d = S_OFF;
          seen_d  = seen_q;
        end
      end
    end

    if (state_d != state_q) cnt_d = '0;

    rst_d   = (state_d == S_ON) ? mask_d : '0;
    on_d    = (state_d == S_ON);
    fault_d = (state_d == S_FAULT);
  end

  assign state      = state_q;
  assign core_rst_n = rst_q;
  assign cluster_on = on_q;
  assign fault      = fault_q;
  assign done_seen  = seen_q;

endmodule

// File: tb/tb_core_state_seq.sv
// Directed bench for core_state_seq.
// Second instance runs with the timeout disabled.
module tb_core_state_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       restart;
  logic [3:0] core_enable;
  logic [3:0] config_done;
  logic [3:0] core_rst_n;
  logic [2:0] state;
  logic       cluster_on;
  logic       fault;
  logic [3:0] done_seen;

  logic       b_start;
  logic       b_restart;
  logic [3:0] b_enable;
  logic [3:0] b_done;
  logic [3:0] b_rst_n;
  logic [2:0] b_state;
  logic       b_on;
  logic       b_fault;
  logic [3:0] b_seen;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] OFF = 3'b000;
  localparam logic [2:0] HLD = 3'b001;
  localparam logic [2:0] CFG = 3'b010;
  localparam logic [2:0] ON  = 3'b011;
  localparam logic [2:0] FLT = 3'b100;

  core_state_seq #(
    .NUM_CORES(4), .HOLD_CYCLES(8),
    .TIMEOUT_CYCLES(16), .CNT_W(16)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .restart(restart),
    .core_enable(core_enable),
    .config_done(config_done),
    .core_rst_n(core_rst_n), .state(state),
    .cluster_on(cluster_on), .fault(fault),
    .done_seen(done_seen)
  );

  core_state_seq #(
    .NUM_CORES(4), .HOLD_CYCLES(8),
    .TIMEOUT_CYCLES(0), .CNT_W(16)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .start(b_start), .restart(b_restart),
    .core_enable(b_enable),
    .config_done(b_done),
    .core_rst_n(b_rst_n), .state(b_state),
    .cluster_on(b_on), .fault(b_fault),
    .done_seen(b_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    restart     = 1'b0;
    core_enable = 4'h0;
    config_done = 4'h0;
    b_start     = 1'b0;
    b_restart   = 1'b0;
    b_enable    = 4'h0;
    b_done      = 4'h0;
    #3;
    chk("rst_state", 32'(state), 32'(OFF));
    chk("rst_core_rst_n", 32'(core_rst_n), 32'h0);
    chk("rst_on", 32'(cluster_on), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_seen", 32'(done_seen), 32'h0);
    #10 rst_n = 1'b1;
    tick(2);

    // basic power-up
    core_enable = 4'hF;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("pu_hold_first", 32'(state), 32'(HLD));
    chk("pu_hold_rst", 32'(core_rst_n), 32'h0);
    tick(7);
    chk("pu_hold_last", 32'(state), 32'(HLD));
    tick(1);
    chk("pu_config", 32'(state), 32'(CFG));
    tick(3);
    chk("pu_config_wait", 32'(state), 32'(CFG));
    config_done = 4'hF;
    tick(1);
    config_done = 4'h0;
    chk("pu_on", 32'(state), 32'(ON));
    chk("pu_rst_rel", 32'(core_rst_n), 32'hF);
    chk("pu_cluster_on", 32'(cluster_on), 32'h1);
    chk("pu_seen", 32'(done_seen), 32'hF);

    // staggered handshake, mask 0101
    core_enable = 4'h5;
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("st_hold", 32'(state), 32'(HLD));
    chk("st_hold_rst", 32'(core_rst_n), 32'h0);
    chk("st_seen_clr", 32'(done_seen), 32'h0);
    chk("st_on_low", 32'(cluster_on), 32'h0);
    tick(8);
    chk("st_config", 32'(state), 32'(CFG));
    config_done = 4'h3;
    tick(1);
    config_done = 4'h2;
    tick(1);
    chk("st_mid_state", 32'(state), 32'(CFG));
    chk("st_mid_seen", 32'(done_seen), 32'h1);
    config_done = 4'h4;
    tick(1);
    config_done = 4'h0;
    chk("st_on", 32'(state), 32'(ON));
    chk("st_rst", 32'(core_rst_n), 32'h5);
    chk("st_seen", 32'(done_seen), 32'h5);

    // start while ON powers down at once
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("off_state", 32'(state), 32'(OFF));
    chk("off_rst", 32'(core_rst_n), 32'h0);
    chk("off_on", 32'(cluster_on), 32'h0);

    // timeout: 3 of 4 cores finish
    core_enable = 4'hF;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(8);
    chk("to_config", 32'(state), 32'(CFG));
    config_done = 4'h7;
    tick(1);
    config_done = 4'h0;
    tick(14);
    chk("to_pre", 32'(state), 32'(CFG));
    tick(1);
    chk("to_fault", 32'(state), 32'(FLT));
    chk("to_fault_flag", 32'(fault), 32'h1);
    chk("to_rst", 32'(core_rst_n), 32'h0);
    chk("to_seen", 32'(done_seen), 32'h7);
    config_done = 4'hF;
    tick(3);
    config_done = 4'h0;
    chk("to_stuck", 32'(state), 32'(FLT));
    chk("to_frozen", 32'(done_seen), 32'h7);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("to_restart", 32'(state), 32'(HLD));
    chk("to_restart_seen", 32'(done_seen), 32'h0);
    chk("to_restart_fault", 32'(fault), 32'h0);

    // done on the final timeout cycle wins
    tick(8);
    chk("last_config", 32'(state), 32'(CFG));
    tick(15);
    chk("last_pre", 32'(state), 32'(CFG));
    config_done = 4'hF;
    tick(1);
    config_done = 4'h0;
    chk("last_on", 32'(state), 32'(ON));
    chk("last_fault", 32'(fault), 32'h0);
    config_done = 4'h0;
    tick(2);
    chk("on_seen_hold", 32'(done_seen), 32'hF);

    // start and restart together while ON
    start = 1'b1;
    restart = 1'b1;
    tick(1);
    start = 1'b0;
    restart = 1'b0;
    chk("pri_hold", 32'(state), 32'(HLD));
    chk("pri_rst", 32'(core_rst_n), 32'h0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("pri_hold_off", 32'(state), 32'(OFF));
    core_enable = 4'h0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("pri_empty", 32'(state), 32'(OFF));

    // async reset mid-CONFIG
    core_enable = 4'hF;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(8);
    config_done = 4'h1;
    tick(1);
    config_done = 4'h0;
    chk("ar_pre_state", 32'(state), 32'(CFG));
    chk("ar_pre_seen", 32'(done_seen), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_state", 32'(state), 32'(OFF));
    chk("ar_seen", 32'(done_seen), 32'h0);
    chk("ar_rst", 32'(core_rst_n), 32'h0);
    chk("ar_on", 32'(cluster_on), 32'h0);
    #2 rst_n = 1'b1;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("ar_hold", 32'(state), 32'(HLD));
    tick(7);
    chk("ar_hold_last", 32'(state), 32'(HLD));
    tick(1);
    chk("ar_config", 32'(state), 32'(CFG));

    // timeout disabled: CONFIG holds indefinitely
    b_enable = 4'hF;
    b_start = 1'b1;
    tick(1);
    b_start = 1'b0;
    tick(8);
    chk("nt_config", 32'(b_state), 32'(CFG));
    tick(5000);
    chk("nt_still", 32'(b_state), 32'(CFG));
    chk("nt_fault", 32'(b_fault), 32'h0);
    chk("nt_rst", 32'(b_rst_n), 32'h0);
    b_done = 4'hF;
    tick(1);
    b_done = 4'h0;
    chk("nt_on", 32'(b_state), 32'(ON));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/core_state_seq.md
Name: core_state_seq

Overview:
Parametrised power-on / restart sequencer for a multi-core cluster. It drives one active-low reset per core and holds every reset for a fixed minimum time. It then waits for per-core configuration-complete handshakes before releasing resets, and enters a FAULT state if configuration times out. It sits between the top-level start/restart controls and the core array; its outputs feed each core's reset input directly.

Parameters:
NUM_CORES, 4, number of core channels (1..32).
HOLD_CYCLES, 8, cycles resets stay asserted in HOLD before CONFIG (>=1).
TIMEOUT_CYCLES, 1024, max cycles in CONFIG before FAULT; 0 disables the timeout.
CNT_W, 16, counter width; must hold max(HOLD_CYCLES, TIMEOUT_CYCLES).

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; power up from OFF, power down from HOLD/CONFIG/ON/FAULT
restart  in  1  single-cycle pulse; re-run the sequence from HOLD
core_enable  in  NUM_CORES  cores to sequence; latched on entry to HOLD
config_done  in  NUM_CORES  per-core configuration complete; level or pulse
core_rst_n  out  NUM_CORES  per-core active-low reset, registered
state  out  3  OFF=000, HOLD=001, CONFIG=010, ON=011, FAULT=100
cluster_on  out  1  high iff state==ON
fault  out  1  high iff state==FAULT
done_seen  out  NUM_CORES  sticky config_done capture for the current sequence, for debug

Behaviour:
- Reset (rst_n low, async): state=OFF, core_rst_n=all 0, cluster_on=0, fault=0, done_seen=0, counter=0, latched mask=0.
- All outputs are registered. core_rst_n, cluster_on and fault update on the same edge as state, so they are never one cycle late.
- Entering HOLD (from any state via restart, or from OFF via start):
  - latch mask = core_enable; clear counter and done_seen.
  - If core_enable==0 on a start from OFF, ignore the request and stay in OFF.
- Priority: restart beats start when both are high in the same cycle, in every state.
- OFF: core_rst_n all 0. start|restart -> HOLD.
- HOLD:
  - core_rst_n all 0; counter increments each cycle.
  - When counter==HOLD_CYCLES-1 -> CONFIG, counter cleared. HOLD lasts exactly HOLD_CYCLES cycles.
  - restart: re-enter HOLD (counter and done_seen cleared, mask re-latched). start: -> OFF.
- CONFIG:
  - core_rst_n all 0 (cores are configured while held in reset).
  - Each cycle, done_seen |= config_done & mask; bits outside mask are ignored and stay 0.
  - When (done_seen | (config_done & mask)) == mask: -> ON on that edge. core_rst_n = mask (enabled cores released, disabled cores stay 0).
  - Otherwise counter increments. If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 -> FAULT.
  - If done and timeout occur on the same edge, done wins (-> ON).
  - restart -> HOLD; start -> OFF.
- ON:
  - core_rst_n = mask.
  - restart -> HOLD: all resets asserted on the same edge.
  - start -> OFF: all resets asserted.
  - config_done ignored; done_seen holds.
- FAULT: core_rst_n all 0, fault=1, done_seen frozen for debug. restart -> HOLD; start -> OFF. No automatic exit.
- Counter saturates; it never wraps inside a state. Any state change clears it.
- Illegal state encodings (101..111) -> OFF on the next edge, with outputs forced to OFF values.
- rst_n asserted mid-sequence: immediate OFF. A subsequent start re-runs the full HOLD with no carried-over counts.

Test Plan:
- Basic power-up (core_enable=4'b1111, HOLD=8): start pulse at edge 0 -> state HOLD edges 1-8, CONFIG at edge 9. config_done=4'b1111 in cycle 12 -> state ON and core_rst_n=4'b1111 at edge 13, cluster_on=1.
- Staggered handshake (mask 4'b0101): config_done pulses 4'b0001 then 4'b0100 two cycles apart, with bit1 glitching high -> ON one edge after the second pulse. core_rst_n=4'b0101; done_seen=4'b0101 (bit1 ignored).
- Timeout (TIMEOUT_CYCLES=16): only 3 of 4 cores finish -> FAULT exactly 16 cycles after CONFIG entry, fault=1, core_rst_n=0. Restart -> HOLD with done_seen=0.
- Done on the final timeout cycle -> ON, not FAULT. TIMEOUT_CYCLES=0 with no done for 5000 cycles -> stays in CONFIG.
- Control priority: start and restart together while ON -> HOLD. start while ON -> OFF with core_rst_n=0 on the same edge. start from OFF with core_enable=0 -> stays OFF.
- Async reset: rst_n low mid-CONFIG between clock edges -> state=OFF and all outputs at reset values immediately. A later start shows a full 8-cycle HOLD.
